// File: rtl/alu_mon_pkg.sv
// Shared types and constants for the ALU result monitor: the captured record
// layout, flag bit positions and the opcode/function-code encodings.
package alu_mon_pkg;

    localparam int REC_W = 74;

    // Positions within the 4-bit flags word {overflow, sign, z, carry}
    localparam int FLAG_CARRY = 0;
    localparam int FLAG_Z     = 1;
    localparam int FLAG_SIGN  = 2;
    localparam int FLAG_OVF   = 3;

    localparam logic [1:0] OP_RTYPE = 2'b00;
    localparam logic [1:0] OP_ITYPE = 2'b01;
    localparam logic [1:0] OP_SHIFT = 2'b10;
    localparam logic [1:0] OP_MISC  = 2'b11;

    typedef enum logic [3:0] {
        F_ADD   = 4'b0000,
        F_SMUL  = 4'b0001,
        F_UMUL  = 4'b0010,
        F_NEG   = 4'b0011,
        F_AND   = 4'b0100,
        F_XOR   = 4'b0101,
        F_SHLL  = 4'b0110,
        F_SHRL  = 4'b0111,
        F_SHRA  = 4'b1000,
        F_SHLLV = 4'b1001,
        F_SHRLV = 4'b1010,
        F_SHRAV = 4'b1011
    } fcode_e;

    typedef struct packed {
        logic [1:0]  opcode;
        logic [3:0]  fcode;
        logic [31:0] out;
        logic [31:0] high;
        logic [3:0]  flags;
    } alu_rec_t;

endpackage

// File: rtl/alu_mon_fifo.sv
// Show-ahead record FIFO with synchronous reset of pointers, count and the
// sticky overflow flag. Storage itself is not reset; the head is masked to 0 when empty.
module alu_mon_fifo #(
    parameter int WIDTH = 74,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     rd_valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     overflow_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             empty, full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = rd_en_i && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_push = wr_en_i && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (wr_en_i && !do_push);
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign rd_valid_o = !empty;
    assign count_o    = count_q;
    assign full_o     = full;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/alu_result_monitor.sv
// Captures ALU result records into a FIFO for later inspection. Defining
// ALU_MON_CHECK_EN adds an expected-value compare with a saturating mismatch counter.
module alu_result_monitor
    import alu_mon_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cap_valid,
    input  logic [1:0]             cap_opcode,
    input  logic [3:0]             cap_fcode,
    input  logic [31:0]            alu_out,
    input  logic [31:0]            alu_high,
    input  logic                   carryFlag,
    input  logic                   zFlag,
    input  logic                   signFlag,
    input  logic                   overflowFlag,
`ifdef ALU_MON_CHECK_EN
    input  logic [31:0]            exp_out,
    input  logic [3:0]             exp_flags,
    output logic                   mismatch,
    output logic [7:0]             mismatch_cnt,
`endif
    input  logic                   rd_en,
    output logic                   rd_valid,
    output logic [31:0]            rd_out,
    output logic [31:0]            rd_high,
    output logic [3:0]             rd_flags,
    output logic [1:0]             rd_opcode,
    output logic [3:0]             rd_fcode,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow
);

    logic [3:0] cap_flags;
    alu_rec_t   cap_rec, head_rec;

    always_comb begin
        cap_flags             = '0;
        cap_flags[FLAG_CARRY] = carryFlag;
        cap_flags[FLAG_Z]     = zFlag;
        cap_flags[FLAG_SIGN]  = signFlag;
        cap_flags[FLAG_OVF]   = overflowFlag;
    end

    assign cap_rec = '{opcode: cap_opcode, fcode: cap_fcode, out: alu_out,
                       high: alu_high, flags: cap_flags};

    alu_mon_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (cap_valid),
        .wr_data_i  (cap_rec),
        .rd_en_i    (rd_en),
        .rd_data_o  (head_rec),
        .rd_valid_o (rd_valid),
        .count_o    (count),
        .full_o     (full),
        .overflow_o (overflow)
    );

    assign rd_opcode = head_rec.opcode;
    assign rd_fcode  = head_rec.fcode;
    assign rd_out    = head_rec.out;
    assign rd_high   = head_rec.high;
    assign rd_flags  = head_rec.flags;

`ifdef ALU_MON_CHECK_EN
    logic       mismatch_q, mismatch_d;
    logic [7:0] mcnt_q, mcnt_d;

    // Compared on every capture, whether or not the FIFO accepts the record
    always_comb begin
        mismatch_d = cap_valid && ((alu_out != exp_out) || (cap_flags != exp_flags));
        mcnt_d     = mcnt_q;
        if (mismatch_d && (mcnt_q != 8'hFF)) mcnt_d = mcnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_q <= 1'b0;
            mcnt_q     <= '0;
        end else begin
            mismatch_q <= mismatch_d;
            mcnt_q     <= mcnt_d;
        end
    end

    assign mismatch     = mismatch_q;
    assign mismatch_cnt = mcnt_q;
`endif

endmodule

// File: tb/tb_alu_result_monitor.sv
// Self-checking bench for alu_result_monitor: directed scenarios plus random
// traffic compared against a queue-based reference model (ALU_MON_CHECK_EN aware).
module tb_alu_result_monitor;
    import alu_mon_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cap_valid = 1'b0;
    logic [1:0]  cap_opcode = '0;
    logic [3:0]  cap_fcode = '0;
    logic [31:0] alu_out = '0, alu_high = '0;
    logic        carryFlag = 1'b0, zFlag = 1'b0, signFlag = 1'b0, overflowFlag = 1'b0;
    logic        rd_en = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_out, rd_high;
    logic [3:0]  rd_flags, rd_fcode;
    logic [1:0]  rd_opcode;
    logic [$clog2(DEPTH):0] count;
    logic        full, overflow;
`ifdef ALU_MON_CHECK_EN
    logic [31:0] exp_out = '0;
    logic [3:0]  exp_flags = '0;
    logic        mismatch;
    logic [7:0]  mismatch_cnt;
`endif

    alu_result_monitor #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .cap_valid    (cap_valid),
        .cap_opcode   (cap_opcode),
        .cap_fcode    (cap_fcode),
        .alu_out      (alu_out),
        .alu_high     (alu_high),
        .carryFlag    (carryFlag),
        .zFlag        (zFlag),
        .signFlag     (signFlag),
        .overflowFlag (overflowFlag),
`ifdef ALU_MON_CHECK_EN
        .exp_out      (exp_out),
        .exp_flags    (exp_flags),
        .mismatch     (mismatch),
        .mismatch_cnt (mismatch_cnt),
`endif
        .rd_en        (rd_en),
        .rd_valid     (rd_valid),
        .rd_out       (rd_out),
        .rd_high      (rd_high),
        .rd_flags     (rd_flags),
        .rd_opcode    (rd_opcode),
        .rd_fcode     (rd_fcode),
        .count        (count),
        .full         (full),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [73:0] mdl_q[$];
    bit          mdl_ovf;
    bit          mdl_mm;
    int          mdl_mcnt;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic [73:0] obs, input logic [73:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_cap(input logic v, input logic [1:0] op, input logic [3:0] fc,
                           input logic [31:0] o, input logic [31:0] h, input logic [3:0] fl);
        cap_valid = v; cap_opcode = op; cap_fcode = fc; alu_out = o; alu_high = h;
        {overflowFlag, signFlag, zFlag, carryFlag} = fl;
`ifdef ALU_MON_CHECK_EN
        exp_out = o; exp_flags = fl;
`endif
    endtask

    task automatic idle();
        set_cap(1'b0, 2'b00, 4'h0, 32'h0, 32'h0, 4'h0);
        rd_en = 1'b0;
    endtask

    // Applies the inputs present at the clock edge to the model
    task automatic model_update();
        logic [3:0] fl;
        bit pop, push;
        fl = {overflowFlag, signFlag, zFlag, carryFlag};
        mdl_mm = 0;
        if (rst) begin
            mdl_q.delete();
            mdl_ovf  = 0;
            mdl_mcnt = 0;
        end else begin
            pop  = rd_en && (mdl_q.size() > 0);
            push = cap_valid && ((mdl_q.size() < DEPTH) || pop);
            if (pop) void'(mdl_q.pop_front());
            if (push) mdl_q.push_back({cap_opcode, cap_fcode, alu_out, alu_high, fl});
            if (cap_valid && !push) mdl_ovf = 1;
`ifdef ALU_MON_CHECK_EN
            if (cap_valid && ((alu_out != exp_out) || (fl != exp_flags))) begin
                mdl_mm = 1;
                if (mdl_mcnt < 255) mdl_mcnt++;
            end
`endif
        end
    endtask

    task automatic check_all(input string tag);
        logic [73:0] head;
        head = (mdl_q.size() > 0) ? mdl_q[0] : 74'd0;
        chk({tag, ".count"}, 74'(count), 74'(mdl_q.size()));
        chk({tag, ".rd_valid"}, 74'(rd_valid), 74'(mdl_q.size() != 0));
        chk({tag, ".full"}, 74'(full), 74'(mdl_q.size() == DEPTH));
        chk({tag, ".overflow"}, 74'(overflow), 74'(mdl_ovf));
        chk({tag, ".head"}, {rd_opcode, rd_fcode, rd_out, rd_high, rd_flags}, head);
`ifdef ALU_MON_CHECK_EN
        chk({tag, ".mismatch"}, 74'(mismatch), 74'(mdl_mm));
        chk({tag, ".mismatch_cnt"}, 74'(mismatch_cnt), 74'(mdl_mcnt));
`endif
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check_all(tag);
    endtask

    initial begin
        mdl_ovf = 0; mdl_mm = 0; mdl_mcnt = 0;
        #1;
        // Reset
        rst = 1'b1; idle();
        step("rst0");
        step("rst1");
        chk("rst.count0", 74'(count), 74'd0);
        chk("rst.rd_out0", 74'(rd_out), 74'd0);
        rst = 1'b0;
        step("post_rst");

        // ADD -5+4 = -1, sign set
        set_cap(1'b1, OP_RTYPE, F_ADD, 32'hFFFFFFFF, 32'h0, 4'b0100);
        step("add_cap");
        idle();
        chk("add.rd_valid", 74'(rd_valid), 74'd1);
        chk("add.rd_out", 74'(rd_out), 74'hFFFFFFFF);
        chk("add.rd_flags", 74'(rd_flags), 74'b0100);
        chk("add.rd_fcode", 74'(rd_fcode), 74'd0);
        chk("add.count", 74'(count), 74'd1);
        rd_en = 1'b1;
        step("add_pop");
        idle();

        // SMUL then UMUL, popped in order
        set_cap(1'b1, OP_RTYPE, F_SMUL, 32'hFFFFFFEC, 32'hFFFFFFFF, 4'b0100);
        step("smul_cap");
        set_cap(1'b1, OP_RTYPE, F_UMUL, 32'hFFFFFFEC, 32'h00000003, 4'b0000);
        step("umul_cap");
        idle();
        chk("mul.count2", 74'(count), 74'd2);
        chk("mul.head_smul", 74'(rd_fcode), 74'(F_SMUL));
        rd_en = 1'b1;
        step("mul_pop1");
        chk("mul.count1", 74'(count), 74'd1);
        chk("mul.head_umul_high", 74'(rd_high), 74'h3);
        step("mul_pop2");
        chk("mul.rd_valid0", 74'(rd_valid), 74'd0);

        // Pops on empty are ignored
        idle(); rd_en = 1'b1;
        for (int i = 0; i < 3; i++) step("empty_pop");
        chk("empty.overflow", 74'(overflow), 74'd0);

        // Fill past capacity
        idle();
        for (int i = 0; i < DEPTH + 1; i++) begin
            set_cap(1'b1, OP_ITYPE, F_XOR, 32'h1000 + 32'(i), 32'(i), 4'(i));
            step("fill");
        end
        idle();
        chk("fill.full", 74'(full), 74'd1);
        chk("fill.count", 74'(count), 74'(DEPTH));
        chk("fill.overflow", 74'(overflow), 74'd1);
        set_cap(1'b1, OP_SHIFT, F_SHRA, 32'hCAFE0000, 32'h5, 4'b1001);
        rd_en = 1'b1;
        step("full_pushpop");
        chk("full_pushpop.count", 74'(count), 74'(DEPTH));
        idle(); rd_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) step("drain");
        idle();

        // Reset mid-stream with records queued; strobes during reset ignored
        for (int i = 0; i < 4; i++) begin
            set_cap(1'b1, OP_MISC, F_NEG, 32'(i * 7), 32'h0, 4'b0010);
            step("q4");
        end
        rst = 1'b1; rd_en = 1'b1;
        step("midrst");
        chk("midrst.count", 74'(count), 74'd0);
        chk("midrst.overflow", 74'(overflow), 74'd0);
        rst = 1'b0; idle();
        step("midrst_rel");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            set_cap(1'($urandom_range(0, 2) != 0), 2'($urandom), 4'($urandom_range(0, 11)),
                    $urandom, $urandom, 4'($urandom));
`ifdef ALU_MON_CHECK_EN
            if ($urandom_range(0, 3) == 0) exp_out = $urandom;
            if ($urandom_range(0, 5) == 0) exp_flags = 4'($urandom);
`endif
            rd_en = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 99) == 0) rst = 1'b1;
            step("rand");
            rst = 1'b0;
        end
        idle();

`ifdef ALU_MON_CHECK_EN
        rst = 1'b1;
        step("chk_rst");
        rst = 1'b0;
        set_cap(1'b1, OP_RTYPE, F_AND, 32'h4, 32'h0, 4'b0000);
        exp_out = 32'h5;
        step("and_mm");
        chk("and.mismatch", 74'(mismatch), 74'd1);
        chk("and.mismatch_cnt", 74'(mismatch_cnt), 74'd1);
        idle();
        step("and_idle");
        chk("and.mismatch_clr", 74'(mismatch), 74'd0);
        for (int i = 0; i < 300; i++) begin
            set_cap(1'b1, OP_RTYPE, F_AND, 32'(i), 32'h0, 4'b0000);
            exp_out = 32'(i) ^ 32'h1;
            rd_en = 1'b1;
            step("sat");
        end
        idle();
        chk("sat.mismatch_cnt", 74'(mismatch_cnt), 74'd255);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_result_monitor.md
ALU_RESULT_MONITOR -- requirements
Module: alu_result_monitor

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, number of result-record slots (power of two, 2..64).
REQ-002 The block SHALL have ports: clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cap_valid  input  1  capture strobe for the current ALU result.
REQ-005 cap_opcode  input  2  / cap_fcode  input  4  opcode and function code that produced the result.
REQ-006 alu_out  input  32  / alu_high  input  32  ALU low and high result words.
REQ-007 carryFlag, zFlag, signFlag, overflowFlag  input  1 each  ALU flags.
REQ-008 rd_en  input  1  pop head record.
REQ-009 rd_valid  output  1  head record present.
REQ-010 rd_out  output  32, rd_high  output  32, rd_flags  output  4 ({overflow,sign,z,carry}), rd_opcode  output  2, rd_fcode  output  4  head record fields.
REQ-011 count  output  clog2(DEPTH)+1  occupancy; full  output  1; overflow  output  1  sticky dropped-capture flag.
REQ-012 With ALU_MON_CHECK_EN only: exp_out  input  32, exp_flags  input  4, mismatch  output  1, mismatch_cnt  output  8.

Function
REQ-013 Record = {opcode, fcode, out, high, flags}, 74 bits, captured in the cycle cap_valid is high.
REQ-014 Push accepted when cap_valid and (not full, or rd_en with rd_valid in the same cycle).
REQ-015 Captured record SHALL appear at rd_* no earlier than the next cycle (1-cycle write latency); rd_* show-ahead, no read latency.
REQ-016 Pop when rd_en and rd_valid; rd_en while empty ignored, no state change.
REQ-017 Simultaneous push and pop: count unchanged, order preserved, legal at full and at one-entry.
REQ-018 Push while full without pop: record dropped, contents unchanged, overflow set next cycle, stays set until reset.
REQ-019 Pointers wrap modulo DEPTH; count range 0..DEPTH; full = (count==DEPTH); rd_valid = (count!=0).
REQ-020 rd_* fields when rd_valid=0 are don't-care for checking but SHALL not be X after reset (memory contents undefined is acceptable only if rd_* forced to 0 when empty).

Reset
REQ-021 On rst: count=0, pointers=0, rd_valid=0, full=0, overflow=0, rd_* = 0, mismatch=0, mismatch_cnt=0.
REQ-022 rst asserted mid-stream SHALL discard all records; cap_valid and rd_en in a reset cycle are ignored.

Configuration
REQ-023 Macro ALU_MON_CHECK_EN defined: each cap_valid cycle compares alu_out vs exp_out and flags vs exp_flags regardless of FIFO state; mismatch registered next cycle (1 for one cycle per failing capture); mismatch_cnt increments and saturates at 255.
REQ-024 Macro not defined: exp_out, exp_flags, mismatch, mismatch_cnt ports and compare logic absent; all other behaviour identical.

Structure
REQ-025 Package alu_mon_pkg SHALL hold the record typedef, flag bit-index constants, and opcode/fcode constants (ADD=0000, SMUL=0001, UMUL=0010, NEG=0011, AND=0100, XOR=0101, SHLL..SHRAV=0110..1011).
REQ-026 Storage SHALL be a sub-module alu_mon_fifo (parameterised width/depth, synchronous reset of pointers/count); compare logic stays in the top.

Verification
REQ-027 Reset, then capture ADD, inp -5+4: alu_out=32'hFFFFFFFF, signFlag=1 -> next cycle rd_valid=1, rd_out=FFFFFFFF, rd_flags=4'b0100, rd_fcode=0000, count=1.
REQ-028 Capture SMUL -5*4 (out=FFFFFFEC, high=FFFFFFFF) then UMUL (out=FFFFFFEC, high=00000003) -> pops return SMUL then UMUL in order, count 2->1->0, rd_valid=0 after.
REQ-029 DEPTH=8: 9 consecutive captures, no pops -> full=1, count=8, overflow=1 after 9th, 9th record absent; then capture+pop same cycle at full -> count stays 8, new record at tail.
REQ-030 rd_en on empty FIFO for 3 cycles -> count=0, rd_valid=0, overflow=0.
REQ-031 ALU_MON_CHECK_EN: capture AND 5&4 with alu_out=4, exp_out=5 -> mismatch=1 one cycle, mismatch_cnt=1; 300 failing captures -> mismatch_cnt=255.
REQ-032 Assert rst with 4 records queued -> next cycle count=0, rd_valid=0, overflow=0, mismatch_cnt=0.
